// File: rtl/sha_block_writer.sv
// rtl/sha_block_writer.sv - SHA-256 message packer/padder writing 512-bit blocks into block RAM
// Packs bytes big-endian, appends 0x80/zero fill/bit length, hands blocks off via valid/ack.
module sha_block_writer #(
   parameter int W     = 32,
   parameter int L     = 16,
   parameter int LEN_W = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_data,
   input  logic                 in_last,
   output logic                 wr_en,
   output logic [$clog2(L)-1:0] wr_addr,
   output logic [W-1:0]         wr_data,
   output logic                 blk_valid,
   output logic                 blk_last,
   input  logic                 blk_ack
);

   localparam int BPW = W / 8;
   localparam int NB  = L * BPW;
   localparam int PW  = $clog2(NB);
   localparam int AW  = $clog2(L);

   typedef enum logic [1:0] {LOAD, PAD, LEN, WAIT} state_t;

   state_t             state, nxt_state;
   logic [PW-1:0]      byte_pos, nxt_byte_pos;
   logic [W-9:0]       acc, nxt_acc;
   logic [LEN_W-1:0]   bit_len, nxt_bit_len;
   logic               pad_first, nxt_pad_first;
   logic               pad_pend, nxt_pad_pend;
   logic               len_phase, nxt_len_phase;
   logic               nxt_wr_en, nxt_blk_valid, nxt_blk_last;
   logic [AW-1:0]      nxt_wr_addr;
   logic [W-1:0]       nxt_wr_data;
   logic               take;
   logic [7:0]         pbyte;

   assign in_ready = (state == LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         byte_pos  <= '0;
         acc       <= '0;
         bit_len   <= '0;
         pad_first <= 1'b0;
         pad_pend  <= 1'b0;
         len_phase <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         blk_valid <= 1'b0;
         blk_last  <= 1'b0;
      end else begin
         state     <= nxt_state;
         byte_pos  <= nxt_byte_pos;
         acc       <= nxt_acc;
         bit_len   <= nxt_bit_len;
         pad_first <= nxt_pad_first;
         pad_pend  <= nxt_pad_pend;
         len_phase <= nxt_len_phase;
         wr_en     <= nxt_wr_en;
         wr_addr   <= nxt_wr_addr;
         wr_data   <= nxt_wr_data;
         blk_valid <= nxt_blk_valid;
         blk_last  <= nxt_blk_last;
      end
   end

   always_comb begin
      nxt_state     = state;
      nxt_byte_pos  = byte_pos;
      nxt_acc       = acc;
      nxt_bit_len   = bit_len;
      nxt_pad_first = pad_first;
      nxt_pad_pend  = pad_pend;
      nxt_len_phase = len_phase;
      nxt_wr_en     = 1'b0;
      nxt_wr_addr   = wr_addr;
      nxt_wr_data   = wr_data;
      nxt_blk_valid = blk_valid;
      nxt_blk_last  = blk_last;
      take          = 1'b0;
      pbyte         = 8'h00;

      case (state)
         LOAD: begin
            if (in_valid) begin
               take        = 1'b1;
               pbyte       = in_data;
               nxt_bit_len = bit_len + LEN_W'(8);
               if (in_last) begin
                  nxt_pad_first = 1'b1;
                  // Last byte filling the block: padding spills into a fresh block.
                  if (byte_pos == PW'(NB - 1)) begin
                     nxt_state    = WAIT;
                     nxt_blk_last = 1'b0;
                     nxt_pad_pend = 1'b1;
                  end else begin
                     nxt_state = PAD;
                  end
               end else if (byte_pos == PW'(NB - 1)) begin
                  nxt_state    = WAIT;
                  nxt_blk_last = 1'b0;
                  nxt_pad_pend = 1'b0;
               end
            end
         end
         PAD: begin
            take          = 1'b1;
            pbyte         = pad_first ? 8'h80 : 8'h00;
            nxt_pad_first = 1'b0;
            if (byte_pos == PW'(NB - 2*BPW - 1)) begin
               nxt_state     = LEN;
               nxt_len_phase = 1'b0;
            end else if (byte_pos == PW'(NB - 1)) begin
               nxt_state    = WAIT;
               nxt_blk_last = 1'b0;
               nxt_pad_pend = 1'b1;
            end
         end
         LEN: begin
            nxt_wr_en     = 1'b1;
            nxt_wr_addr   = len_phase ? AW'(L - 1) : AW'(L - 2);
            nxt_wr_data   = len_phase ? bit_len[W-1:0] : bit_len[2*W-1:W];
            nxt_len_phase = 1'b1;
            if (len_phase) begin
               nxt_state    = WAIT;
               nxt_blk_last = 1'b1;
            end
         end
         WAIT: begin
            if (!blk_valid) begin
               nxt_blk_valid = 1'b1;
            end else if (blk_ack) begin
               nxt_blk_valid = 1'b0;
               nxt_byte_pos  = '0;
               if (blk_last) begin
                  nxt_state    = LOAD;
                  nxt_bit_len  = '0;
                  nxt_blk_last = 1'b0;
               end else if (pad_pend) begin
                  nxt_state = PAD;
               end else begin
                  nxt_state = LOAD;
               end
            end
         end
         default: nxt_state = LOAD;
      endcase

      // Shared packer for message and pad bytes; a word is written after its 4th byte.
      if (take) begin
         nxt_acc      = {acc[W-17:0], pbyte};
         nxt_byte_pos = byte_pos + PW'(1);
         if (byte_pos[1:0] == 2'd3) begin
            nxt_wr_en   = 1'b1;
            nxt_wr_addr = byte_pos[PW-1 -: AW];
            nxt_wr_data = {acc, pbyte};
         end
      end
   end

endmodule
